// File: rtl/ntt_pkg.sv
// Shared constants, mode encodings and controller state type for the 14-bit NTT datapath.
package ntt_pkg;

  localparam int unsigned Q        = 12289;
  localparam int unsigned DATA_W   = 14;

  localparam int unsigned DefN     = 256;
  localparam int unsigned DefLogN  = 8;
  localparam int unsigned DefRdLat = 1;
  localparam int unsigned DefBfLat = 6;

  localparam logic MODE_FWD = 1'b0;
  localparam logic MODE_INV = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StFin
  } state_e;

endpackage

// File: rtl/ctrl_delay.sv
// Fixed-depth shift register with asynchronous active-low clear.
module ctrl_delay #(
  parameter int unsigned Depth = 1,
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] pipe_q [Depth];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < Depth; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= d_i;
      for (int unsigned i = 1; i < Depth; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign q_o = pipe_q[Depth-1];

endmodule

// File: rtl/ntt_bf_ctrl.sv
// Stage/address sequencer for one NTT butterfly: issues reads and twiddle addresses per stage
// and replays write addresses after the memory plus butterfly latency.
module ntt_bf_ctrl
  import ntt_pkg::*;
#(
  parameter int unsigned N      = DefN,
  parameter int unsigned LOG_N  = DefLogN,
  parameter int unsigned RD_LAT = DefRdLat,
  parameter int unsigned BF_LAT = DefBfLat
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             mode_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             rd_en_o,
  output logic [LOG_N-1:0] rd_addr_u_o,
  output logic [LOG_N-1:0] rd_addr_v_o,
  output logic [LOG_N-1:0] tw_addr_o,
  output logic             bf_sel_o,
  output logic             wr_en_o,
  output logic [LOG_N-1:0] wr_addr_u_o,
  output logic [LOG_N-1:0] wr_addr_v_o
);

  localparam int unsigned LAT  = RD_LAT + BF_LAT;
  localparam int unsigned CntW = $clog2(LAT + 1);
  localparam int unsigned DlyW = 2 * LOG_N + 1;

  localparam logic [LOG_N-1:0] JLast   = LOG_N'(N / 2 - 1);
  localparam logic [LOG_N-1:0] SLast   = LOG_N'(LOG_N - 1);
  localparam logic [CntW-1:0]  CntLast = CntW'(LAT - 1);

  state_e           state_q, state_d;
  logic [LOG_N-1:0] s_q, s_d, j_q, j_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             mode_q, mode_d;

  logic             busy_q, busy_d, done_q, done_d, sel_q, sel_d;
  logic             rd_en_q, rd_en_d;
  logic [LOG_N-1:0] u_q, u_d, v_q, v_d, tw_q, tw_d;

  int unsigned      lh;
  logic [LOG_N-1:0] h, blk;

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    j_d     = j_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StRun;
          mode_d  = mode_i;
          s_d     = '0;
          j_d     = '0;
        end
      end
      StRun: begin
        if (j_q == JLast) begin
          state_d = StDrain;
          cnt_d   = '0;
        end else begin
          j_d = j_q + LOG_N'(1);
        end
      end
      StDrain: begin
        if (cnt_q == CntLast) begin
          if (s_q == SLast) begin
            state_d = StFin;
          end else begin
            state_d = StRun;
            s_d     = s_q + LOG_N'(1);
            j_d     = '0;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StFin: state_d = StIdle;
    endcase
  end

  // Outputs are computed from next-state so that they appear registered in the issuing cycle.
  always_comb begin
    lh      = (mode_d == MODE_INV) ? 32'(s_d) : LOG_N - 1 - 32'(s_d);
    h       = LOG_N'(1) << lh;
    blk     = j_d >> lh;
    u_d     = (blk << (lh + 1)) | (j_d & (h - LOG_N'(1)));
    v_d     = u_d + h;
    tw_d    = (LOG_N'(1) << (LOG_N - 1 - lh)) + blk;
    rd_en_d = (state_d == StRun);
    busy_d  = (state_d == StRun) || (state_d == StDrain);
    done_d  = (state_d == StFin);
    sel_d   = busy_d & mode_d;
    if (!rd_en_d) begin
      u_d  = '0;
      v_d  = '0;
      tw_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      s_q     <= '0;
      j_q     <= '0;
      cnt_q   <= '0;
      mode_q  <= MODE_FWD;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sel_q   <= 1'b0;
      rd_en_q <= 1'b0;
      u_q     <= '0;
      v_q     <= '0;
      tw_q    <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      j_q     <= j_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sel_q   <= sel_d;
      rd_en_q <= rd_en_d;
      u_q     <= u_d;
      v_q     <= v_d;
      tw_q    <= tw_d;
    end
  end

  ctrl_delay #(
    .Depth (LAT),
    .Width (DlyW)
  ) u_wr_dly (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    ({rd_en_q, u_q, v_q}),
    .q_o    ({wr_en_o, wr_addr_u_o, wr_addr_v_o})
  );

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign bf_sel_o    = sel_q;
  assign rd_en_o     = rd_en_q;
  assign rd_addr_u_o = u_q;
  assign rd_addr_v_o = v_q;
  assign tw_addr_o   = tw_q;

endmodule

// File: doc/ntt_bf_ctrl.md
# ntt_bf_ctrl

Stage/address sequencer for one butterfly unit of the 14-bit NTT datapath (q = 12289). On a start request it walks every stage of an N-point transform, in forward order (mode 0, Cooley-Tukey) or inverse order (mode 1, Gentleman-Sande with halving). Each cycle it issues u/v read addresses, a twiddle address and the butterfly `sel`, and replays the matching write addresses after the combined memory plus butterfly latency. It sits between the top-level NTT FSM and the coefficient RAM, twiddle ROM and butterfly unit.

## Interface
- `N`, 256, transform length; power of two, 4..1024
- `LOG_N`, 8, log2(N); also the address width
- `RD_LAT`, 1, coefficient RAM read latency in cycles
- `BF_LAT`, 6, butterfly unit input-to-output latency in cycles
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle request; sampled only in IDLE
- `mode`  in  1  0 = forward, 1 = inverse; latched on accepted `start`
- `busy`  out  1  high from the cycle after an accepted `start` until `done`
- `done`  out  1  one-cycle pulse at completion
- `rd_en`  out  1  read strobe for both RAM ports
- `rd_addr_u`, `rd_addr_v`  out  LOG_N  read addresses
- `tw_addr`  out  LOG_N  twiddle ROM address, aligned with `rd_en`
- `bf_sel`  out  1  butterfly mode select; equals the latched `mode` while `busy`
- `wr_en`  out  1  write strobe
- `wr_addr_u`, `wr_addr_v`  out  LOG_N  write addresses

## Operation
- **FSM states:** IDLE, RUN, DRAIN, FIN.
  - IDLE & `start` → RUN: latch `mode`; stage `s` = 0, pair counter `j` = 0.
  - RUN: issue one butterfly per cycle, `rd_en` = 1, `j` += 1. When `j` = N/2-1 is issued → DRAIN.
  - DRAIN: hold `rd_en` = 0 for exactly LAT = RD_LAT + BF_LAT cycles, so the last write of a stage lands before the next stage reads.
    - Then, if `s` < LOG_N-1: `s` += 1, `j` = 0, → RUN.
    - Otherwise → FIN.
  - FIN: `done` = 1 for one cycle, → IDLE.
- **Half-span `h`:**
  - forward: `h` = N >> (s+1)
  - inverse: `h` = 1 << s
  - `lh` = log2(h)
- **Addresses:**
  - `rd_addr_u` = `j` with a 0 inserted at bit `lh`, i.e. ((`j` >> `lh`) << (`lh`+1)) | (`j` & (h-1))
  - `rd_addr_v` = `rd_addr_u` + h
  - `tw_addr` = N/(2h) + (`j` >> `lh`)
- **Write path:**
  - `{rd_en, rd_addr_u, rd_addr_v}` enter a LAT-deep delay line.
  - Its output drives `{wr_en, wr_addr_u, wr_addr_v}` directly.
- `start` while not in IDLE is ignored. `mode` changes while `busy` have no effect.
- **Reset (asynchronous, any state):**
  - All outputs go to 0, the FSM goes to IDLE and the delay line is cleared.
  - No write is emitted after reset, even if the reset lands mid-stage.
- All arithmetic is unsigned LOG_N-bit. `rd_addr_v` never wraps: `rd_addr_u` < N-h by construction.

## Timing
- `start` accepted at edge t. From t+1: `busy` = 1, RUN, first `rd_en`.
- Each stage is N/2 read cycles followed by LAT drain cycles.
- `wr_en` for the read issued at cycle c is asserted at c+LAT.
- `done` is asserted at t+1 + LOG_N·(N/2+LAT). `busy` falls the same cycle `done` goes high.
- A new `start` is accepted the cycle after `done`.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `ntt_pkg`:
  - Q = 12289 and DATA_W = 14
  - default N/LOG_N, RD_LAT, BF_LAT
  - mode encodings MODE_FWD = 0, MODE_INV = 1
  - FSM state encodings
- One sub-module, `ctrl_delay`: a parameterised depth/width shift register with async active-low clear. It is used for the write-address delay line.
- The address generator stays inline in `ntt_bf_ctrl`.

## Test plan
All scenarios use N=16, LAT=7.
- Reset mid-RUN (stage 1, `j` = 3) → all outputs 0 immediately; no `wr_en` afterwards; a fresh `start` runs cleanly from stage 0.
- Forward, stage 0:
  - `j` = 0 → u=0, v=8, tw=1
  - `j` = 5 → u=5, v=13, tw=1
- Forward, stage 3:
  - `j` = 5 → u=10, v=11, tw=13
- Inverse, stage 0:
  - `j` = 3 → u=6, v=7, tw=11
  - `bf_sel` = 1 throughout
- Inverse, stage 3:
  - `j` = 2 → u=2, v=10, tw=1
- Full forward run → `done` exactly 4·(8+7) = 60 cycles after the first `busy` cycle.
  - Exactly 32 `wr_en` pulses, each at read+7 with matching addresses.
  - No read in a stage precedes the last write of the previous stage.
- `start` pulsed during RUN and DRAIN → ignored. `start` held high in the cycle after `done` → a second run begins.
